// File: rtl/regread_slice_sched.sv
// regread_slice_sched
// Round-robin scheduler for the byte-sliced physical register file read path.
// Up to PORTS lane requests are granted per cycle. Each grant then walks
// through SLICES slice stages, reading one SRAM slice per cycle. Completion
// is flagged in the cycle the last slice is read.
// Optional feature: define REGREAD_SLICE_PERF_EN to build saturating
// grant and conflict counters. Without it, both perf outputs are tied to 0.

module regread_slice_sched #(
    parameter int  LANES    = 4,
    parameter int  PORTS    = 2,
    parameter int  SLICES   = 4,
    parameter int  PHYS_LOG = 7,
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int INF_W    = $clog2(PORTS * SLICES + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [LANES-1:0]                 req_valid_i,
    input  logic [LANES*PHYS_LOG-1:0]        req_tag_i,
    input  logic                             stall_i,
    input  logic                             flush_i,
    output logic [LANES-1:0]                 grant_o,
    output logic [SLICES*PORTS-1:0]          slice_en_o,
    output logic [SLICES*PORTS*PHYS_LOG-1:0] slice_addr_o,
    output logic [PORTS-1:0]                 done_valid_o,
    output logic [PORTS*LANE_W-1:0]          done_lane_o,
    output logic [PORTS*PHYS_LOG-1:0]        done_tag_o,
    output logic [INF_W-1:0]                 inflight_o,
    output logic [31:0]                      perf_grant_o,
    output logic [31:0]                      perf_conflict_o
);

    logic [LANE_W-1:0]   rr_ptr;
    logic [LANE_W-1:0]   scan_idx;
    logic [LANE_W-1:0]   last_lane;
    int                  n_gnt;
    logic [PORTS-1:0]    port_vld;
    logic [PHYS_LOG-1:0] port_tag  [PORTS];
    logic [LANE_W-1:0]   port_lane [PORTS];

    logic [PORTS-1:0]    st_valid     [SLICES];
    logic [PORTS-1:0]    st_valid_nxt [SLICES];
    logic [PHYS_LOG-1:0] st_tag       [SLICES][PORTS];
    logic [LANE_W-1:0]   st_lane      [SLICES][PORTS];
    logic [INF_W-1:0]    inflight_nxt;

    // Round-robin scan from rr_ptr. The j-th granted lane is steered to port j.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path leaves a bit unassigned and no latch is
        // inferred.
        grant_o   = '0;
        port_vld  = '0;
        last_lane = rr_ptr;
        scan_idx  = '0;
        n_gnt     = 0;
        for (int p = 0; p < PORTS; p++) begin
            port_tag[p]  = '0;
            port_lane[p] = '0;
        end
        // No grants during reset, stall or flush. The stage-0 inputs below
        // therefore see an empty cycle in all three cases.
        if (reset && !stall_i && !flush_i) begin
            for (int i = 0; i < LANES; i++) begin
                scan_idx = LANE_W'((int'(rr_ptr) + i) % LANES);
                if (req_valid_i[scan_idx] && n_gnt < PORTS) begin
                    grant_o[scan_idx] = 1'b1;
                    for (int p = 0; p < PORTS; p++) begin
                        if (p == n_gnt) begin
                            port_vld[p]  = 1'b1;
                            port_tag[p]  = req_tag_i[scan_idx*PHYS_LOG +: PHYS_LOG];
                            port_lane[p] = scan_idx;
                        end
                    end
                    last_lane = scan_idx;
                    n_gnt     = n_gnt + 1;
                end
            end
        end
    end

    // Next stage valids: flush empties the pipe, stall holds it, otherwise
    // it shifts by one slice. Occupancy is counted from the next state.
    always_comb begin
        for (int k = 0; k < SLICES; k++) begin
            st_valid_nxt[k] = st_valid[k];
        end
        if (flush_i) begin
            for (int k = 0; k < SLICES; k++) begin
                st_valid_nxt[k] = '0;
            end
        end else if (!stall_i) begin
            st_valid_nxt[0] = port_vld;
            for (int k = 1; k < SLICES; k++) begin
                st_valid_nxt[k] = st_valid[k-1];
            end
        end
        inflight_nxt = '0;
        for (int k = 0; k < SLICES; k++) begin
            for (int p = 0; p < PORTS; p++) begin
                inflight_nxt = inflight_nxt + INF_W'(st_valid_nxt[k][p]);
            end
        end
    end

    // Stage valids, round-robin pointer and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SLICES; k++) begin
                st_valid[k] <= '0;
            end
            rr_ptr     <= '0;
            inflight_o <= '0;
        end else begin
            // NOTE: non-blocking updates make every stage sample pre-edge
            // values. A blocking '=' would let st[k] pick up st[k-1]'s new
            // value within the same edge.
            for (int k = 0; k < SLICES; k++) begin
                st_valid[k] <= st_valid_nxt[k];
            end
            inflight_o <= inflight_nxt;
            if (flush_i) begin
                rr_ptr <= '0;
            end else if (n_gnt != 0) begin
                rr_ptr <= LANE_W'((int'(last_lane) + 1) % LANES);
            end
        end
    end

    // Tag and lane payload follows the valids through the slice stages.
    // NOTE: payload flops carry no reset. Every consumer qualifies them with
    // the matching stage valid, and those valids are reset.
    always_ff @(posedge clk) begin
        if (!stall_i && !flush_i) begin
            for (int p = 0; p < PORTS; p++) begin
                st_tag[0][p]  <= port_tag[p];
                st_lane[0][p] <= port_lane[p];
            end
            for (int k = 1; k < SLICES; k++) begin
                for (int p = 0; p < PORTS; p++) begin
                    st_tag[k][p]  <= st_tag[k-1][p];
                    st_lane[k][p] <= st_lane[k-1][p];
                end
            end
        end
    end

    // Slice read enables/addresses and completion, all silenced by stall.
    always_comb begin
        slice_en_o   = '0;
        slice_addr_o = '0;
        done_valid_o = '0;
        done_lane_o  = '0;
        done_tag_o   = '0;
        for (int k = 0; k < SLICES; k++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (st_valid[k][p] && !stall_i) begin
                    slice_en_o[k*PORTS+p]                          = 1'b1;
                    slice_addr_o[(k*PORTS+p)*PHYS_LOG +: PHYS_LOG] = st_tag[k][p];
                end
            end
        end
        for (int p = 0; p < PORTS; p++) begin
            if (st_valid[SLICES-1][p] && !stall_i) begin
                done_valid_o[p]                     = 1'b1;
                done_lane_o[p*LANE_W +: LANE_W]     = st_lane[SLICES-1][p];
                done_tag_o[p*PHYS_LOG +: PHYS_LOG]  = st_tag[SLICES-1][p];
            end
        end
    end

`ifdef REGREAD_SLICE_PERF_EN
    int          n_req;
    logic [31:0] perf_grant_q;
    logic [31:0] perf_conflict_q;
    logic [32:0] grant_sum;

    // Number of lanes requesting this cycle.
    always_comb begin
        n_req = 0;
        for (int l = 0; l < LANES; l++) begin
            n_req = n_req + int'(req_valid_i[l]);
        end
    end

    assign grant_sum = {1'b0, perf_grant_q} + 33'(n_gnt);

    // Saturating counters. Only reset clears them; flush leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grant_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_grant_q <= grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
            if (n_req > n_gnt && perf_conflict_q != 32'hFFFF_FFFF) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_grant_o    = perf_grant_q;
    assign perf_conflict_o = perf_conflict_q;
`else
    assign perf_grant_o    = '0;
    assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_regread_slice_sched.sv
// tb_regread_slice_sched
// Directed stimulus for regread_slice_sched. Stimulus checks grants, slice
// enables and occupancy in place. Every grant also pushes its expected
// completion (cycle, lane, tag) into a per-port queue. A monitor compares
// each done_valid_o pulse against the head of that queue.

module tb_regread_slice_sched;

    localparam int LANES    = 4;
    localparam int PORTS    = 2;
    localparam int SLICES   = 4;
    localparam int PHYS_LOG = 7;
    localparam int LANE_W   = 2;
    localparam int INF_W    = 4;

`ifdef REGREAD_SLICE_PERF_EN
    localparam logic [31:0] EXP_PERF_GRANT    = 32'd20;
    localparam logic [31:0] EXP_PERF_CONFLICT = 32'd10;
`else
    localparam logic [31:0] EXP_PERF_GRANT    = 32'd0;
    localparam logic [31:0] EXP_PERF_CONFLICT = 32'd0;
`endif

    logic                             clk = 1'b0;
    logic                             reset;
    logic [LANES-1:0]                 req_valid_i;
    logic [LANES*PHYS_LOG-1:0]        req_tag_i;
    logic                             stall_i;
    logic                             flush_i;
    logic [LANES-1:0]                 grant_o;
    logic [SLICES*PORTS-1:0]          slice_en_o;
    logic [SLICES*PORTS*PHYS_LOG-1:0] slice_addr_o;
    logic [PORTS-1:0]                 done_valid_o;
    logic [PORTS*LANE_W-1:0]          done_lane_o;
    logic [PORTS*PHYS_LOG-1:0]        done_tag_o;
    logic [INF_W-1:0]                 inflight_o;
    logic [31:0]                      perf_grant_o;
    logic [31:0]                      perf_conflict_o;

    regread_slice_sched #(
        .LANES   (LANES),
        .PORTS   (PORTS),
        .SLICES  (SLICES),
        .PHYS_LOG(PHYS_LOG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_tag_i      (req_tag_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .grant_o        (grant_o),
        .slice_en_o     (slice_en_o),
        .slice_addr_o   (slice_addr_o),
        .done_valid_o   (done_valid_o),
        .done_lane_o    (done_lane_o),
        .done_tag_o     (done_tag_o),
        .inflight_o     (inflight_o),
        .perf_grant_o   (perf_grant_o),
        .perf_conflict_o(perf_conflict_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int                  cyc;
        logic [LANE_W-1:0]   lane;
        logic [PHYS_LOG-1:0] tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_done(input int port, input int dcyc, input int lane, input int tag);
        exp_t e;
        e.cyc  = dcyc;
        e.lane = LANE_W'(lane);
        e.tag  = PHYS_LOG'(tag);
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tag(input int lane, input int tag);
        req_tag_i[lane*PHYS_LOG +: PHYS_LOG] = PHYS_LOG'(tag);
    endtask

    // Completion monitor: every done pulse must match the next expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   have;
        if (reset === 1'b1) begin
            for (int p = 0; p < PORTS; p++) begin
                if (done_valid_o[p] === 1'b1) begin
                    have = 1'b0;
                    if (p == 0 && q0.size() > 0) begin
                        e    = q0.pop_front();
                        have = 1'b1;
                    end else if (p == 1 && q1.size() > 0) begin
                        e    = q1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL done_unexpected_p%0d: got lane %0d tag 0x%0h at cycle %0d, expected no completion",
                                 p, done_lane_o[p*LANE_W +: LANE_W], done_tag_o[p*PHYS_LOG +: PHYS_LOG], cyc);
                    end else begin
                        check($sformatf("done_cycle_p%0d", p), 64'(cyc), 64'(e.cyc));
                        check($sformatf("done_lane_p%0d", p), 64'(done_lane_o[p*LANE_W +: LANE_W]), 64'(e.lane));
                        check($sformatf("done_tag_p%0d", p), 64'(done_tag_o[p*PHYS_LOG +: PHYS_LOG]), 64'(e.tag));
                    end
                end
            end
        end
    end

    // Stall test: per-cycle stall, lane-0 request, expected enables and occupancy.
    logic       c_stall [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    logic [7:0] c_en    [8] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h04, 8'h10, 8'h40, 8'h00};
    int         c_inf   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};

    // Perf test: three lanes requesting, round-robin repeats every 3 cycles.
    logic [3:0] e_grant [3] = '{4'b0011, 4'b0101, 4'b0110};
    int         e_p0    [3] = '{0, 2, 1};
    int         e_p1    [3] = '{1, 0, 2};

    int inf_a [7] = '{0, 2, 4, 4, 4, 2, 0};

    initial begin
        int         t;
        logic [7:0] ee;
        logic [55:0] ea;

        reset       = 1'b1;
        req_valid_i = '0;
        req_tag_i   = '0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        #1 reset = 1'b0;

        // Reset held low with random inputs: every output stays 0.
        for (int i = 0; i < 4; i++) begin
            step();
            req_valid_i = LANES'($urandom);
            req_tag_i   = (LANES*PHYS_LOG)'($urandom);
            stall_i     = 1'($urandom);
            flush_i     = 1'($urandom);
            @(negedge clk);
            check("rst_grant", 64'(grant_o), 0);
            check("rst_slice_en", 64'(slice_en_o), 0);
            check("rst_slice_addr", 64'(slice_addr_o), 0);
            check("rst_done_valid", 64'(done_valid_o), 0);
            check("rst_done_lane", 64'(done_lane_o), 0);
            check("rst_done_tag", 64'(done_tag_o), 0);
            check("rst_inflight", 64'(inflight_o), 0);
            check("rst_perf_grant", 64'(perf_grant_o), 0);
            check("rst_perf_conflict", 64'(perf_conflict_o), 0);
        end
        step();
        req_valid_i = '0;
        req_tag_i   = '0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        check("post_rst_inflight", 64'(inflight_o), 0);
        step();
        step();

        // All four lanes for two cycles, tags 0x10..0x13.
        step();
        t = cyc;
        req_valid_i = 4'b1111;
        for (int l = 0; l < LANES; l++) set_tag(l, 'h10 + l);
        push_done(0, t + 4, 0, 'h10);
        push_done(1, t + 4, 1, 'h11);
        @(negedge clk);
        check("A_grant_c0", 64'(grant_o), 4'b0011);
        check("A_inflight_c0", 64'(inflight_o), 64'(inf_a[0]));
        step();
        push_done(0, t + 5, 2, 'h12);
        push_done(1, t + 5, 3, 'h13);
        @(negedge clk);
        check("A_grant_c1", 64'(grant_o), 4'b1100);
        check("A_slice_en_c1", 64'(slice_en_o), 8'b0000_0011);
        check("A_slice_addr_c1", 64'(slice_addr_o), 56'h890);
        check("A_inflight_c1", 64'(inflight_o), 64'(inf_a[1]));
        step();
        req_valid_i = '0;
        @(negedge clk);
        check("A_slice_en_c2", 64'(slice_en_o), 8'b0000_1111);
        check("A_inflight_c2", 64'(inflight_o), 64'(inf_a[2]));
        for (int c = 3; c < 7; c++) begin
            step();
            @(negedge clk);
            check($sformatf("A_inflight_c%0d", c), 64'(inflight_o), 64'(inf_a[c]));
        end
        step();

        // Lane 2 alone, tag 0x15: walks slices 0..3 on port 0.
        step();
        t = cyc;
        req_valid_i = 4'b0100;
        set_tag(2, 'h15);
        push_done(0, t + 4, 2, 'h15);
        @(negedge clk);
        check("B_grant", 64'(grant_o), 4'b0100);
        for (int k = 1; k <= 4; k++) begin
            step();
            req_valid_i = '0;
            ee = 8'd1 << ((k - 1) * PORTS);
            ea = 56'h15 << ((k - 1) * PORTS * PHYS_LOG);
            @(negedge clk);
            check($sformatf("B_slice_en_c%0d", k), 64'(slice_en_o), 64'(ee));
            check($sformatf("B_slice_addr_c%0d", k), 64'(slice_addr_o), 64'(ea));
        end
        step();
        step();

        // Stall in cycles 2-3 after a single grant (rr_ptr now 3, lane 3).
        step();
        t = cyc;
        req_valid_i = 4'b1000;
        set_tag(3, 'h2A);
        push_done(0, t + 6, 3, 'h2A);
        @(negedge clk);
        check("C_grant_c0", 64'(grant_o), 4'b1000);
        for (int c = 1; c < 8; c++) begin
            step();
            stall_i     = c_stall[c];
            req_valid_i = c_stall[c] ? 4'b0001 : 4'b0000;
            @(negedge clk);
            check($sformatf("C_grant_c%0d", c), 64'(grant_o), 0);
            check($sformatf("C_slice_en_c%0d", c), 64'(slice_en_o), 64'(c_en[c]));
            check($sformatf("C_inflight_c%0d", c), 64'(inflight_o), 64'(c_inf[c]));
        end
        step();
        step();

        // Flush together with stall while 4 entries are in flight.
        step();
        t = cyc;
        req_valid_i = 4'b0110;
        set_tag(1, 'h31);
        set_tag(2, 'h32);
        @(negedge clk);
        check("D_grant_c0", 64'(grant_o), 4'b0110);
        step();
        req_valid_i = 4'b1001;
        set_tag(0, 'h30);
        set_tag(3, 'h33);
        @(negedge clk);
        check("D_grant_c1", 64'(grant_o), 4'b1001);
        check("D_inflight_c1", 64'(inflight_o), 2);
        step();
        req_valid_i = '0;
        stall_i     = 1'b1;
        flush_i     = 1'b1;
        @(negedge clk);
        check("D_inflight_c2", 64'(inflight_o), 4);
        check("D_slice_en_c2", 64'(slice_en_o), 0);
        check("D_done_c2", 64'(done_valid_o), 0);
        check("D_grant_c2", 64'(grant_o), 0);
        step();
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 4'b1111;
        for (int l = 0; l < LANES; l++) set_tag(l, 'h40 + l);
        push_done(0, t + 7, 0, 'h40);
        push_done(1, t + 7, 1, 'h41);
        @(negedge clk);
        check("D_inflight_c3", 64'(inflight_o), 0);
        check("D_slice_en_c3", 64'(slice_en_o), 0);
        check("D_grant_c3_rr0", 64'(grant_o), 4'b0011);
        step();
        req_valid_i = '0;
        @(negedge clk);
        check("D_inflight_c4", 64'(inflight_o), 2);
        check("D_slice_en_c4", 64'(slice_en_o), 8'b0000_0011);
        for (int i = 0; i < 8; i++) step();

        // Fresh reset, then three lanes requesting for 10 cycles.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        check("E_perf_grant_rst", 64'(perf_grant_o), 0);
        check("E_perf_conflict_rst", 64'(perf_conflict_o), 0);
        for (int c = 0; c < 10; c++) begin
            step();
            t = cyc;
            req_valid_i = 4'b0111;
            for (int l = 0; l < LANES; l++) set_tag(l, 'h50 + l);
            push_done(0, t + 4, e_p0[c % 3], 'h50 + e_p0[c % 3]);
            push_done(1, t + 4, e_p1[c % 3], 'h50 + e_p1[c % 3]);
            @(negedge clk);
            check($sformatf("E_grant_c%0d", c), 64'(grant_o), 64'(e_grant[c % 3]));
        end
        step();
        req_valid_i = '0;
        @(negedge clk);
        check("E_perf_grant", 64'(perf_grant_o), 64'(EXP_PERF_GRANT));
        check("E_perf_conflict", 64'(perf_conflict_o), 64'(EXP_PERF_CONFLICT));
        for (int i = 0; i < 8; i++) step();

        check("q0_pending", 64'(q0.size()), 0);
        check("q1_pending", 64'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
